// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stage enables and squash controls for the 5-stage in-order core.
//            Optional STALL_PERF_CNT_EN adds stall/bubble cycle counters.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_memread,
    input  logic       ex_mem_branch_taken,
    input  logic       ex_mem_jump,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       ex_mem_flush,
    output logic       mem_err,
    output logic [1:0] state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2,
        ST_RSVD     = 2'd3
    } state_e;

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            mem_err_q, mem_err_d;

    logic mem_stall;
    logic redirect;
    logic load_use;
    logic bubble_active;

    // ERR releases the pending access, so it never stalls.
    assign mem_stall     = arst_n & mem_req & ~mem_ack & (state_q != ST_ERR);
    assign redirect      = ex_mem_branch_taken | ex_mem_jump;
    assign load_use      = id_ex_memread & (id_ex_rd != 5'd0) &
                           ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
    assign bubble_active = arst_n & ~mem_stall & ~redirect & load_use;

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        if (arst_n && !mem_stall) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_RUN;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_RUN;
            end
            default: begin
                // The reserved encoding behaves exactly like RUN.
                state_d = ST_RUN;
                if (mem_req && !mem_ack) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = TO_W'(1);
                end
            end
        endcase
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_cycles_q, bubble_cycles_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        bubble_cycles_d = bubble_cycles_q;
        if (mem_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (bubble_active && (bubble_cycles_q != 32'hFFFF_FFFF)) begin
            bubble_cycles_d = bubble_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cycles_q  <= 32'd0;
            bubble_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            bubble_cycles_q <= bubble_cycles_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_active;
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign state   = state_q;
    assign mem_err = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed plus randomized bench for pipeline_hazard_ctrl against a
//            behavioural model of the hazard priority rules.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
    logic        id_ex_memread, ex_mem_branch_taken, ex_mem_jump;
    logic        mem_req, mem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_bubble, ex_mem_flush, mem_err;
    logic [1:0]  state;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles, bubble_cycles;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .TO_W(8)) dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .if_id_rs1           (if_id_rs1),
        .if_id_rs2           (if_id_rs2),
        .id_ex_rd            (id_ex_rd),
        .id_ex_memread       (id_ex_memread),
        .ex_mem_branch_taken (ex_mem_branch_taken),
        .ex_mem_jump         (ex_mem_jump),
        .mem_req             (mem_req),
        .mem_ack             (mem_ack),
        .pc_en               (pc_en),
        .if_id_en            (if_id_en),
        .id_ex_en            (id_ex_en),
        .ex_mem_en           (ex_mem_en),
        .mem_wb_en           (mem_wb_en),
        .if_id_flush         (if_id_flush),
        .id_ex_bubble        (id_ex_bubble),
        .ex_mem_flush        (ex_mem_flush),
        .mem_err             (mem_err),
        .state               (state)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles        (stall_cycles),
        .bubble_cycles       (bubble_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=RUN 1=waiting on memory 2=ERR.
    int          m_mode     = 0;
    int          m_stall_run = 0;
    bit          m_err      = 1'b0;
    longint      m_stall_n  = 0;
    longint      m_bub_n    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        arst_n              = 1'b1;
        if_id_rs1           = 5'd0;
        if_id_rs2           = 5'd0;
        id_ex_rd            = 5'd0;
        id_ex_memread       = 1'b0;
        ex_mem_branch_taken = 1'b0;
        ex_mem_jump         = 1'b0;
        mem_req             = 1'b0;
        mem_ack             = 1'b0;
    endtask

    // Check the current cycle's outputs, then advance one clock and the model.
    task automatic cycle(input string tag);
        logic [4:0] e_en;
        logic [2:0] e_sq;
        bit stall, redir, lu, bub;
        #2;
        stall = arst_n && mem_req && !mem_ack && (m_mode != 2);
        redir = ex_mem_branch_taken || ex_mem_jump;
        lu    = id_ex_memread && (id_ex_rd != 0) &&
                ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
        bub   = 1'b0;
        if (!arst_n || stall) begin
            e_en = 5'b00000; e_sq = 3'b000;
        end else if (redir) begin
            e_en = 5'b11111; e_sq = 3'b111;
        end else if (lu) begin
            e_en = 5'b00111; e_sq = 3'b010; bub = 1'b1;
        end else begin
            e_en = 5'b11111; e_sq = 3'b000;
        end
        check({tag, "/en"}, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e_en});
        check({tag, "/squash"}, {29'd0, if_id_flush, id_ex_bubble, ex_mem_flush}, {29'd0, e_sq});
        check({tag, "/state"}, {30'd0, state}, m_mode);
        check({tag, "/mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
`ifdef STALL_PERF_CNT_EN
        check({tag, "/stall_cnt"}, stall_cycles, m_stall_n[31:0]);
        check({tag, "/bubble_cnt"}, bubble_cycles, m_bub_n[31:0]);
`endif
        @(posedge clk);
        if (!arst_n) begin
            m_mode = 0; m_stall_run = 0; m_err = 1'b0; m_stall_n = 0; m_bub_n = 0;
        end else begin
            if (stall && m_stall_n < 64'hFFFF_FFFF) m_stall_n++;
            if (bub && m_bub_n < 64'hFFFF_FFFF) m_bub_n++;
            if (m_mode == 0) begin
                if (mem_req && !mem_ack) begin
                    m_mode = 1; m_stall_run = 1;
                end
            end else if (m_mode == 1) begin
                if (mem_ack) begin
                    m_mode = 0;
                end else begin
                    m_stall_run++;
                    // Stall may last MT+1 cycles in total before giving up.
                    if (m_stall_run == MT + 1) begin
                        m_mode = 2; m_err = 1'b1;
                    end
                end
            end else begin
                m_mode = 0;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        arst_n  = 1'b0;
        mem_req = 1'b1;
        id_ex_memread = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3;
        @(posedge clk);
        #1;
        cycle("reset0");
        ex_mem_jump = 1'b1;
        cycle("reset1");

        idle(); cycle("idle");

        // Load-use on rs2, then the load moves on and the hazard clears.
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd1; if_id_rs2 = 5'd5;
        cycle("loaduse");
        check("loaduse_pc_en", {31'd0, pc_en}, 32'd0);
        idle(); cycle("loaduse_after");
        id_ex_memread = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
        cycle("loaduse_x0");

        // Memory stall acknowledged on the 4th cycle.
        idle(); mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle("memstall");
        mem_ack = 1'b1; cycle("memstall_ack");
        idle();
`ifdef STALL_PERF_CNT_EN
        check("perf_stall_total", stall_cycles, 32'd3);
        check("perf_bubble_total", bubble_cycles, 32'd1);
`endif

        // Redirect dominates a simultaneous load-use.
        ex_mem_jump = 1'b1; id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5;
        cycle("redirect_lu");
        idle(); ex_mem_branch_taken = 1'b1; cycle("branch");

        // Timeout: MT+1 stall cycles, one ERR cycle, then RUN with sticky error.
        idle(); mem_req = 1'b1;
        for (int i = 0; i < MT + 1; i++) cycle("timeout_stall");
        check("timeout_state", {30'd0, state}, 32'd2);
        cycle("timeout_err");
        idle();
        for (int i = 0; i < 3; i++) cycle("after_err");
        check("err_sticky", {31'd0, mem_err}, 32'd1);

        // Reset asserted in the middle of a stall.
        mem_req = 1'b1;
        cycle("rst_mid_a"); cycle("rst_mid_b");
        arst_n = 1'b0; cycle("rst_mid_hold");
        check("rst_mid_state", {30'd0, state}, 32'd0);
        check("rst_mid_err", {31'd0, mem_err}, 32'd0);
        idle(); cycle("rst_mid_release");

        for (int n = 0; n < 3000; n++) begin
            arst_n              = ($urandom_range(99) >= 2);
            mem_req             = ($urandom_range(99) < 35);
            mem_ack             = ($urandom_range(99) < 30);
            ex_mem_branch_taken = ($urandom_range(99) < 10);
            ex_mem_jump         = ($urandom_range(99) < 8);
            id_ex_memread       = ($urandom_range(99) < 50);
            id_ex_rd            = 5'($urandom_range(3));
            if_id_rs1           = 5'($urandom_range(3));
            if_id_rs2           = 5'($urandom_range(3));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
